// File: rtl/bridge_rx_ascii.sv
// bridge_rx_ascii: turns ASCII "R<4 hex><CR|LF>" / "W<8 hex><CR|LF>" frames
// from the host UART into single-cycle addr/wdata/rdata/rw/valid bus strobes.
// Ports: clk, rst (async, active-high), data_i/valid_i (received byte),
//        addr_o/wdata_o/rdata_o/rw_o/valid_o (bus), err_count_o (bad frames).
// Option: define BRIDGE_RX_LOWERCASE_EN to accept a-f digits and r/w commands.
module bridge_rx_ascii #(
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  data_i,
    input  logic        valid_i,
    output logic [15:0] addr_o,
    output logic [15:0] wdata_o,
    output logic [15:0] rdata_o,
    output logic        rw_o,
    output logic        valid_o,
    output logic [7:0]  err_count_o
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE
    } state_t;

    state_t      state_q;
    state_t      state_n;
    state_t      cur;
    logic [3:0]  cnt_q;
    logic [3:0]  cnt_n;
    logic [3:0]  need;
    logic [31:0] sr_q;
    logic [31:0] sr_n;
    logic        emit;
    logic [15:0] addr_n;
    logic [15:0] wdata_n;
    logic        rw_n;
    logic [1:0]  err_inc;
    logic [8:0]  err_sum;
    logic [7:0]  err_n;
    logic        tmo;

    logic        is_hex;
    logic [3:0]  nib;
    logic        is_r;
    logic        is_w;
    logic        is_term;

    assign rdata_o = 16'h0000;

    // Byte classification
    always_comb begin
        is_hex = 1'b0;
        nib    = 4'h0;
        if (data_i >= 8'h30 && data_i <= 8'h39) begin
            is_hex = 1'b1;
            nib    = data_i[3:0];
        end else if (data_i >= 8'h41 && data_i <= 8'h46) begin
            // 'A'..'F' have low nibble 1..6
            is_hex = 1'b1;
            nib    = data_i[3:0] + 4'd9;
        end
`ifdef BRIDGE_RX_LOWERCASE_EN
        else if (data_i >= 8'h61 && data_i <= 8'h66) begin
            is_hex = 1'b1;
            nib    = data_i[3:0] + 4'd9;
        end
`endif
        is_r = (data_i == 8'h52);
        is_w = (data_i == 8'h57);
`ifdef BRIDGE_RX_LOWERCASE_EN
        if (data_i == 8'h72) is_r = 1'b1;
        if (data_i == 8'h77) is_w = 1'b1;
`endif
        is_term = (data_i == 8'h0D) || (data_i == 8'h0A);
    end

    // Inter-byte gap timeout
    generate
        if (TIMEOUT_CYCLES > 0) begin : g_tmo
            localparam int GW = $clog2(TIMEOUT_CYCLES + 1);
            logic [GW-1:0] gap_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    gap_q <= '0;
                end else if (state_n == IDLE || valid_i) begin
                    gap_q <= '0;
                end else begin
                    gap_q <= gap_q + GW'(1);
                end
            end

            assign tmo = (state_q != IDLE) &&
                         (gap_q == GW'(TIMEOUT_CYCLES));
        end else begin : g_no_tmo
            assign tmo = 1'b0;
        end
    endgenerate

    // Next-state / emission logic
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        sr_n    = sr_q;
        emit    = 1'b0;
        addr_n  = addr_o;
        wdata_n = wdata_o;
        rw_n    = rw_o;
        err_inc = {1'b0, tmo};
        // A timeout wins; a byte in the same cycle is then seen by IDLE
        cur     = tmo ? IDLE : state_q;
        need    = (cur == WRITE) ? 4'd8 : 4'd4;

        if (tmo) state_n = IDLE;

        if (valid_i) begin
            case (cur)
                IDLE: begin
                    if (is_r) begin
                        state_n = READ;
                        cnt_n   = 4'd0;
                    end else if (is_w) begin
                        state_n = WRITE;
                        cnt_n   = 4'd0;
                    end else if (!is_term) begin
                        err_inc = err_inc + 2'd1;
                    end
                end
                default: begin
                    if (is_r || is_w) begin
                        // Re-sync on a fresh command byte
                        err_inc = err_inc + 2'd1;
                        state_n = is_w ? WRITE : READ;
                        cnt_n   = 4'd0;
                    end else if (is_hex && cnt_q < need) begin
                        sr_n  = {sr_q[27:0], nib};
                        cnt_n = cnt_q + 4'd1;
                    end else if (is_term && cnt_q == need) begin
                        emit    = 1'b1;
                        state_n = IDLE;
                        if (cur == WRITE) begin
                            addr_n  = sr_q[31:16];
                            wdata_n = sr_q[15:0];
                            rw_n    = 1'b1;
                        end else begin
                            addr_n  = sr_q[15:0];
                            wdata_n = 16'h0000;
                            rw_n    = 1'b0;
                        end
                    end else begin
                        err_inc = err_inc + 2'd1;
                        state_n = IDLE;
                    end
                end
            endcase
        end
    end

    assign err_sum = {1'b0, err_count_o} + {7'd0, err_inc};
    assign err_n   = err_sum[8] ? 8'hFF : err_sum[7:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            sr_q        <= 32'h0;
            addr_o      <= 16'h0000;
            wdata_o     <= 16'h0000;
            rw_o        <= 1'b0;
            valid_o     <= 1'b0;
            err_count_o <= 8'h00;
        end else begin
            state_q     <= state_n;
            cnt_q       <= cnt_n;
            sr_q        <= sr_n;
            addr_o      <= addr_n;
            wdata_o     <= wdata_n;
            rw_o        <= rw_n;
            valid_o     <= emit;
            err_count_o <= err_n;
        end
    end

endmodule

// File: tb/tb_bridge_rx_ascii.sv
// tb_bridge_rx_ascii: scoreboard bench for bridge_rx_ascii with a
// byte-level frame model, directed frames and randomized traffic.
module tb_bridge_rx_ascii;

    localparam int TO = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  data_i;
    logic        valid_i;
    logic [15:0] addr_o;
    logic [15:0] wdata_o;
    logic [15:0] rdata_o;
    logic        rw_o;
    logic        valid_o;
    logic [7:0]  err_count_o;

    bridge_rx_ascii #(.TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .data_i      (data_i),
        .valid_i     (valid_i),
        .addr_o      (addr_o),
        .wdata_o     (wdata_o),
        .rdata_o     (rdata_o),
        .rw_o        (rw_o),
        .valid_o     (valid_o),
        .err_count_o (err_count_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          at;
        logic [15:0] a;
        logic [15:0] w;
        logic        rw;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int vec  = 0;
    int miss = 0;

    // Reference model state
    int m_mode = 0;   // 0 none, 1 read frame, 2 write frame
    int m_last = 0;   // edge of last byte that kept the frame alive
    int m_err  = 0;
    int m_dig[$];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic m_tmo(int at);
        if (m_mode != 0 && at >= m_last + TO + 1) begin
            m_err++;
            m_mode = 0;
        end
    endtask

    task automatic m_byte(logic [7:0] b, int at);
        int          v;
        bit          hx;
        bit          isr;
        bit          isw;
        bit          term;
        int          need;
        logic [31:0] val;
        exp_t        e;
        m_tmo(at);
        hx = 0;
        v  = 0;
        if (b >= 8'h30 && b <= 8'h39) begin
            hx = 1; v = int'(b) - 48;
        end else if (b >= 8'h41 && b <= 8'h46) begin
            hx = 1; v = int'(b) - 65 + 10;
        end
`ifdef BRIDGE_RX_LOWERCASE_EN
        else if (b >= 8'h61 && b <= 8'h66) begin
            hx = 1; v = int'(b) - 97 + 10;
        end
        isr  = (b == 8'h52) || (b == 8'h72);
        isw  = (b == 8'h57) || (b == 8'h77);
`else
        isr  = (b == 8'h52);
        isw  = (b == 8'h57);
`endif
        term = (b == 8'h0D) || (b == 8'h0A);
        if (m_mode == 0) begin
            if (isr || isw) begin
                m_mode = isr ? 1 : 2;
                m_dig.delete();
                m_last = at;
            end else if (!term) begin
                m_err++;
            end
        end else begin
            need = (m_mode == 1) ? 4 : 8;
            if (isr || isw) begin
                m_err++;
                m_mode = isr ? 1 : 2;
                m_dig.delete();
                m_last = at;
            end else if (hx && m_dig.size() < need) begin
                m_dig.push_back(v);
                m_last = at;
            end else if (term && m_dig.size() == need) begin
                val = 0;
                foreach (m_dig[i]) val = val * 16 + 32'(m_dig[i]);
                e.at = at;
                if (m_mode == 1) begin
                    e.a = val[15:0]; e.w = 16'h0; e.rw = 1'b0;
                end else begin
                    e.a = val[31:16]; e.w = val[15:0]; e.rw = 1'b1;
                end
                exp_q.push_back(e);
                m_mode = 0;
            end else begin
                m_err++;
                m_mode = 0;
            end
        end
    endtask

    // Called at a falling edge; the byte is sampled at the next rising edge
    task automatic send(logic [7:0] b);
        data_i  = b;
        valid_i = 1'b1;
        m_byte(b, cyc + 1);
        @(negedge clk);
        valid_i = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_str(string s, int gap);
        for (int i = 0; i < s.len(); i++) begin
            send(s[i]);
            idle(gap);
        end
    endtask

    task automatic check_err(string nm);
        m_tmo(cyc);
        chk(nm, 32'(err_count_o), (m_err > 255) ? 32'd255 : 32'(m_err));
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        valid_i = 1'b0;
        m_mode  = 0;
        m_err   = 0;
        exp_q.delete();
        idle(2);
        rst = 1'b0;
    endtask

    function automatic int pick_gap();
        int r;
        r = $urandom_range(0, 99);
        if (r < 70) return 0;
        if (r < 95) return $urandom_range(1, 3);
        return $urandom_range(9, 12);
    endfunction

    // Monitor: pops the scoreboard on every bus strobe
    always @(negedge clk) begin
        if (!rst && valid_o) begin
            if (exp_q.size() == 0) begin
                vec++;
                miss++;
                $display("FAIL unexpected_pulse: got addr %h rw %b, expected none (cycle %0d)",
                         addr_o, rw_o, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("pulse_cycle", 32'(cyc), 32'(mon_e.at));
                chk("addr", 32'(addr_o), 32'(mon_e.a));
                chk("wdata", 32'(wdata_o), 32'(mon_e.w));
                chk("rw", 32'(rw_o), 32'(mon_e.rw));
                chk("rdata", 32'(rdata_o), 32'h0);
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        string       hexu;
        string       hexl;
        string       junk;
        logic [7:0]  fb[$];
        int          k;
        hexu    = "0123456789ABCDEF";
        hexl    = "0123456789abcdef";
        junk    = "RWGrwxZ 0F9-";
        rst     = 1'b1;
        valid_i = 1'b0;
        data_i  = 8'h00;
        idle(2);
        rst = 1'b0;
        idle(1);

        chk("rst_addr", 32'(addr_o), 32'h0);
        chk("rst_wdata", 32'(wdata_o), 32'h0);
        chk("rst_rdata", 32'(rdata_o), 32'h0);
        chk("rst_rw", 32'(rw_o), 32'h0);
        chk("rst_valid", 32'(valid_o), 32'h0);
        chk("rst_err", 32'(err_count_o), 32'h0);

        // Read, back-to-back bytes
        send_str("R1234", 0); send(8'h0D); idle(2);
        check_err("read_err");

        // Write with gaps, then a harmless CRLF
        send_str("W00FFBEEF", 3); send(8'h0A); idle(3);
        send(8'h0D); send(8'h0A); idle(2);
        check_err("write_err");

        // Bad digit mid-frame
        send_str("R12G", 0);
        check_err("bad_digit_err");
        send_str("4", 0); send(8'h0D); idle(2);
        check_err("bad_digit_tail_err");

        // Short frame
        send_str("R123", 0); send(8'h0D); idle(2);
        check_err("short_err");

        // Re-sync on W
        send_str("R12W0001ABCD", 0); send(8'h0D); idle(2);
        check_err("resync_err");

        // Inter-byte timeout
        send_str("R12", 0); idle(TO);
        send_str("34", 0); send(8'h0D); idle(2);
        check_err("timeout_err");

        // Lowercase command and digits
        send_str("r00ab", 0); send(8'h0D); idle(2);
        check_err("lower_err");

        // Reset mid-frame
        send_str("W1234AB", 0);
        do_reset();
        chk("midrst_addr", 32'(addr_o), 32'h0);
        chk("midrst_err", 32'(err_count_o), 32'h0);
        send_str("5678", 0); send(8'h0D); idle(2);
        check_err("midrst_tail_err");
        send_str("R0002", 0); send(8'h0D); idle(2);

        // Error counter saturation
        do_reset();
        repeat (260) send(8'h47);
        check_err("sat_err");
        send_str("W0FED1234", 0); send(8'h0D); idle(2);
        check_err("sat_hold_err");

        // Randomized traffic
        do_reset();
        for (int f = 0; f < 250; f++) begin
            fb.delete();
            k = $urandom_range(0, 9);
            if (k < 8) begin
                if ($urandom_range(0, 15) == 0)
                    fb.push_back((k < 4) ? 8'h72 : 8'h77);
                else
                    fb.push_back((k < 4) ? 8'h52 : 8'h57);
                for (int d = 0; d < ((k < 4) ? 4 : 8); d++) begin
                    if ($urandom_range(0, 19) == 0)
                        fb.push_back(hexl[$urandom_range(0, 15)]);
                    else
                        fb.push_back(hexu[$urandom_range(0, 15)]);
                end
                fb.push_back(($urandom_range(0, 1) == 1) ? 8'h0D : 8'h0A);
                if ($urandom_range(0, 3) == 0) fb.push_back(8'h0A);
                if ($urandom_range(0, 9) == 0)
                    fb[$urandom_range(0, fb.size() - 1)] =
                        junk[$urandom_range(0, junk.len() - 1)];
                if ($urandom_range(0, 19) == 0)
                    void'(fb.pop_back());
            end else begin
                repeat ($urandom_range(1, 3))
                    fb.push_back(junk[$urandom_range(0, junk.len() - 1)]);
            end
            foreach (fb[i]) begin
                send(fb[i]);
                idle(pick_gap());
            end
            if (f % 25 == 24) check_err("rand_err");
        end

        idle(TO + 10);
        check_err("final_err");
        chk("pending_pulses", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule

// File: doc/bridge_rx_ascii.md
# bridge_rx_ascii

Parses an ASCII command byte stream from the host UART receiver into single-cycle bus transactions. It drives the `addr`/`wdata`/`rdata`/`rw`/`valid` bus that enters the first core of the chain, for example the logic analyzer's `addr_i` port. Read frames are `R` followed by 4 hex digits and a terminator. Write frames are `W` followed by 4 hex address digits, 4 hex data digits and a terminator. Malformed frames are dropped and counted.

## Interface
- `TIMEOUT_CYCLES`, default 0: maximum clock cycles allowed between consecutive bytes of one frame. A value of 0 disables the timeout.
- `clk` input 1: system clock; all logic is on its rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `data_i` input 8: received byte.
- `valid_i` input 1: `data_i` is valid this cycle. Each such cycle carries exactly one byte.
- `addr_o` output 16: transaction address.
- `wdata_o` output 16: write data. Equals 0 for reads.
- `rdata_o` output 16: constant 0. This block is the bus origin.
- `rw_o` output 1: 1 = write, 0 = read.
- `valid_o` output 1: one-cycle transaction strobe.
- `err_count_o` output 8: count of malformed frames. Saturates at 255.

## Operation
- States:
  - IDLE: waiting for a command byte.
  - READ: collecting 4 address digits, then a terminator.
  - WRITE: collecting 8 digits, then a terminator.
- A 4-bit digit counter and a 32-bit digit shift register track progress.
- Hex digits: `0`–`9` and `A`–`F`, ASCII uppercase only (unless the macro below is enabled). Digits shift in MSB first.
- Terminators: CR (0x0D) or LF (0x0A).
- IDLE:
  - `R` clears the counter and moves to READ.
  - `W` clears the counter and moves to WRITE.
  - CR/LF are ignored silently, so CRLF pairs cost nothing.
  - Any other byte increments the error count and stays in IDLE.
- READ/WRITE, hex digit with counter below the required count (4 or 8): shift it in and increment the counter.
- READ/WRITE, terminator with counter equal to the required count: emit the transaction, go to IDLE.
- READ/WRITE error cases. Each increments the error count and goes to IDLE:
  - terminator before all digits are received;
  - hex digit after all digits are received;
  - any other non-hex byte.
- Exception: an `R` or `W` byte mid-frame increments the error count, then restarts a frame of the new type immediately (re-sync).
- Transaction emission:
  - READ: `addr_o` = the 4 digits, `wdata_o` = 0, `rw_o` = 0.
  - WRITE: `addr_o` = digits 1–4, `wdata_o` = digits 5–8, `rw_o` = 1.
- `addr_o`, `wdata_o` and `rw_o` hold their values until the next transaction.
- Timeout, when `TIMEOUT_CYCLES` > 0:
  - A gap counter resets on every accepted byte and increments each cycle in READ/WRITE.
  - When it reaches `TIMEOUT_CYCLES`, the error count increments and the state returns to IDLE.
  - The gap counter width is `$clog2(TIMEOUT_CYCLES+1)`.
- `err_count_o` saturates at 255 and never wraps.

## Timing
- Reset values: state IDLE; `addr_o`, `wdata_o`, `rdata_o` = 0; `rw_o`, `valid_o` = 0; `err_count_o` = 0; counters cleared.
- Latency: `valid_o` is high exactly one cycle, in the cycle after the terminator byte's `valid_i` cycle. `addr_o`, `wdata_o` and `rw_o` update in that same cycle.
- Back-to-back input:
  - Bytes may arrive on consecutive cycles with no bubbles required.
  - A new frame's `R`/`W` can be accepted the cycle after a terminator.
  - Back-to-back transactions are therefore spaced at least 6 cycles apart (read) or 10 cycles apart (write).
- There is no backpressure. Downstream cores must accept a transaction every `valid_o` pulse.
- Timeout takes priority over a byte arriving in the same cycle the limit is reached. That byte is then processed in IDLE.
- Reset mid-frame drops the frame with no `valid_o` and clears `err_count_o`. A `valid_o` pulse pending at reset assertion is suppressed.

## Configuration
- `BRIDGE_RX_LOWERCASE_EN` defined: lowercase `a`–`f` are accepted as hex digits, and `r`/`w` are accepted as commands.
- Undefined: lowercase bytes are invalid and handled as errors per Operation.

## Test plan
- Read: bytes `R1234` CR, consecutive cycles → one `valid_o` pulse the cycle after CR, with `addr_o`=0x1234, `rw_o`=0, `wdata_o`=0. `err_count_o` stays 0.
- Write with gaps: `W00FFBEEF` LF, 3 idle cycles between bytes (`TIMEOUT_CYCLES`=0) → `addr_o`=0x00FF, `wdata_o`=0xBEEF, `rw_o`=1, one pulse. A trailing CRLF pair adds no error.
- Malformed frames:
  - `R12G4` CR → no `valid_o`; `err_count_o`=1 after `G`; the trailing `4` and CR are then handled in IDLE (`4` increments the count).
  - `R123` CR → 1 error.
  - `R12W0001ABCD` CR → 1 error, then a write with `addr_o`=0x0001, `wdata_o`=0xABCD.
- Timeout: `TIMEOUT_CYCLES`=10; send `R12`, wait 10 cycles, then send `34` CR → timeout increments the error count. No `valid_o` occurs, and the `3` and `4` bytes each count as further errors.
- Lowercase: `r00ab` CR → with the macro, `addr_o`=0x00AB and one pulse; without it, no pulse and the error count is nonzero.
- Reset: assert `rst` after `W1234AB` → state returns to IDLE. `5678` CR then produces no pulse, and `R0002` CR afterwards reads address 0x0002.
